// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared definitions for the digital clock blocks: time field
//               widths, field limits and the alarm ring controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Time field widths
    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    // Field limits
    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;

    // Alarm ring controller states; codes 5..7 are unused and recover to IDLE
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_RING   = 3'd2,
        ST_SNOOZE = 3'd3,
        ST_DONE   = 3'd4
    } alarm_state_e;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/time_add_min.sv
`default_nettype none
// ============================================================================
// Module      : time_add_min
// Description : Combinational hh:mm + N minutes with minute carry into the
//               hour and 24-hour wrap. N must be 0..59.
// Ports       : hr_i/min_i  - base time (0..23 / 0..59)
//               add_i       - minutes to add (0..59)
//               hr_o/min_o  - resulting time (0..23 / 0..59)
// Revision    : 1.0 - initial release
// ============================================================================
module time_add_min
    import clock_pkg::*;
(
    input  logic [HR_W-1:0]  hr_i,
    input  logic [MIN_W-1:0] min_i,
    input  logic [MIN_W-1:0] add_i,
    output logic [HR_W-1:0]  hr_o,
    output logic [MIN_W-1:0] min_o
);

    localparam logic [MIN_W:0]  c_min_wrap = (MIN_W+1)'(MIN_MAX + 1);
    localparam logic [HR_W-1:0] c_hr_max   = HR_W'(HR_MAX);

    logic [MIN_W:0]  w_min_sum;
    logic [MIN_W:0]  w_min_wrapped;
    logic            w_carry;

    // One extra bit: 59 + 59 = 118 still fits in 7 bits
    assign w_min_sum     = {1'b0, min_i} + {1'b0, add_i};
    assign w_carry       = (w_min_sum >= c_min_wrap);
    assign w_min_wrapped = w_min_sum - c_min_wrap;

    always_comb begin
        min_o = w_min_sum[MIN_W-1:0];
        hr_o  = hr_i;
        if (w_carry) begin
            min_o = w_min_wrapped[MIN_W-1:0];
            // Hour 23 rolls over to 0 rather than reaching 24
            hr_o  = (hr_i >= c_hr_max) ? '0 : hr_i + HR_W'(1);
        end
    end

endmodule : time_add_min
`default_nettype wire

// File: rtl/alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ring_ctrl
// Description : Alarm buzzer sequencer. Compares running time against the
//               alarm register, rings the buzzer in a 1 s on/off pattern and
//               handles snooze, dismiss, ring timeout and disarm.
// Ports       : clk, rst_n           - clock, async active-low reset
//               sec_tick_i          - one-cycle pulse per second
//               cur_hr/min/sec_i    - running time
//               alarm_hr/min_i      - stored alarm time
//               alarm_arm_i         - alarm enabled (level)
//               alarm_edit_i        - alarm register being edited (level)
//               snooze_i/dismiss_i  - conditioned button pulses
//               buzzer_o            - buzzer drive
//               ringing_o/snoozed_o - status LEDs
//               snooze_hr/min_o     - latched snooze target
//               state_o             - current state code
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ring_ctrl
    import clock_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sec_tick_i,
    input  logic [HR_W-1:0]  cur_hr_i,
    input  logic [MIN_W-1:0] cur_min_i,
    input  logic [SEC_W-1:0] cur_sec_i,
    input  logic [HR_W-1:0]  alarm_hr_i,
    input  logic [MIN_W-1:0] alarm_min_i,
    input  logic             alarm_arm_i,
    input  logic             alarm_edit_i,
    input  logic             snooze_i,
    input  logic             dismiss_i,
    output logic             buzzer_o,
    output logic             ringing_o,
    output logic             snoozed_o,
    output logic [HR_W-1:0]  snooze_hr_o,
    output logic [MIN_W-1:0] snooze_min_o,
    output logic [2:0]       state_o
);

    localparam int              SC_W            = $clog2(MAX_SNOOZE + 2);
    localparam logic [SC_W-1:0] c_max_snooze    = SC_W'(MAX_SNOOZE);
    localparam logic [7:0]      c_ring_timeout  = 8'(RING_TIMEOUT_S);
    localparam logic [MIN_W-1:0] c_snooze_add   = MIN_W'(SNOOZE_MIN);

    alarm_state_e     state_q;
    logic             buzzer_q;
    logic             ringing_q;
    logic             snoozed_q;
    logic [HR_W-1:0]  snooze_hr_q;
    logic [MIN_W-1:0] snooze_min_q;
    logic [SC_W-1:0]  snooze_cnt_q;
    logic [7:0]       ring_cnt_q;

    logic             w_match_a;
    logic             w_match_s;
    logic             w_same_minute;
    logic [HR_W-1:0]  w_tgt_hr;
    logic [MIN_W-1:0] w_tgt_min;
    logic [7:0]       w_ring_cnt_inc;

    assign w_same_minute  = (cur_hr_i == alarm_hr_i) && (cur_min_i == alarm_min_i);
    assign w_match_a      = w_same_minute && (cur_sec_i == '0) && !alarm_edit_i;
    assign w_match_s      = (cur_hr_i == snooze_hr_q) && (cur_min_i == snooze_min_q)
                            && (cur_sec_i == '0);
    assign w_ring_cnt_inc = ring_cnt_q + 8'd1;

    // Snooze target is always computed from the current time; it is only
    // captured on the RING -> SNOOZE transition.
    time_add_min u_snooze_tgt (
        .hr_i  (cur_hr_i),
        .min_i (cur_min_i),
        .add_i (c_snooze_add),
        .hr_o  (w_tgt_hr),
        .min_o (w_tgt_min)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozed_q    <= 1'b0;
            snooze_hr_q  <= '0;
            snooze_min_q <= '0;
            snooze_cnt_q <= '0;
            ring_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    buzzer_q  <= 1'b0;
                    ringing_q <= 1'b0;
                    snoozed_q <= 1'b0;
                    if (alarm_arm_i && !alarm_edit_i) begin
                        state_q      <= ST_ARMED;
                        snooze_cnt_q <= '0;
                    end
                end

                ST_ARMED, ST_RING, ST_SNOOZE, ST_DONE: begin
                    if (!alarm_arm_i) begin
                        // Disarm overrides everything, including a pending match
                        state_q      <= ST_IDLE;
                        buzzer_q     <= 1'b0;
                        ringing_q    <= 1'b0;
                        snoozed_q    <= 1'b0;
                        snooze_cnt_q <= '0;
                        ring_cnt_q   <= '0;
                    end else begin
                        case (state_q)
                            ST_ARMED: begin
                                if (w_match_a) begin
                                    state_q    <= ST_RING;
                                    buzzer_q   <= 1'b1;
                                    ringing_q  <= 1'b1;
                                    ring_cnt_q <= '0;
                                end
                            end

                            ST_RING: begin
                                if (dismiss_i) begin
                                    state_q   <= ST_DONE;
                                    buzzer_q  <= 1'b0;
                                    ringing_q <= 1'b0;
                                end else if (snooze_i) begin
                                    buzzer_q  <= 1'b0;
                                    ringing_q <= 1'b0;
                                    if (snooze_cnt_q < c_max_snooze) begin
                                        state_q      <= ST_SNOOZE;
                                        snoozed_q    <= 1'b1;
                                        snooze_hr_q  <= w_tgt_hr;
                                        snooze_min_q <= w_tgt_min;
                                        snooze_cnt_q <= snooze_cnt_q + SC_W'(1);
                                    end else begin
                                        // Snooze budget exhausted: behaves as dismiss
                                        state_q <= ST_DONE;
                                    end
                                end else if (sec_tick_i) begin
                                    ring_cnt_q <= w_ring_cnt_inc;
                                    if (w_ring_cnt_inc >= c_ring_timeout) begin
                                        state_q   <= ST_DONE;
                                        buzzer_q  <= 1'b0;
                                        ringing_q <= 1'b0;
                                    end else begin
                                        buzzer_q <= ~buzzer_q;
                                    end
                                end
                            end

                            ST_SNOOZE: begin
                                buzzer_q <= 1'b0;
                                if (dismiss_i) begin
                                    state_q   <= ST_DONE;
                                    snoozed_q <= 1'b0;
                                end else if (w_match_s) begin
                                    state_q    <= ST_RING;
                                    buzzer_q   <= 1'b1;
                                    ringing_q  <= 1'b1;
                                    snoozed_q  <= 1'b0;
                                    ring_cnt_q <= '0;
                                end
                            end

                            ST_DONE: begin
                                buzzer_q <= 1'b0;
                                // Wait out the alarm minute so the match cannot re-fire
                                if (!w_same_minute) begin
                                    state_q      <= ST_ARMED;
                                    snooze_cnt_q <= '0;
                                end
                            end

                            default: ;
                        endcase
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    buzzer_q  <= 1'b0;
                    ringing_q <= 1'b0;
                    snoozed_q <= 1'b0;
                end
            endcase
        end
    end

    assign buzzer_o     = buzzer_q;
    assign ringing_o    = ringing_q;
    assign snoozed_o    = snoozed_q;
    assign snooze_hr_o  = snooze_hr_q;
    assign snooze_min_o = snooze_min_q;
    assign state_o      = state_q;

endmodule : alarm_ring_ctrl
`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ring_ctrl
// Description : Directed self-checking bench for alarm_ring_ctrl with
//               MAX_SNOOZE=2, SNOOZE_MIN=5, RING_TIMEOUT_S=60. Expected
//               outputs are queued as stimulus is applied and compared after
//               the corresponding clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ring_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sec_tick;
    logic [4:0] cur_hr, alarm_hr;
    logic [5:0] cur_min, cur_sec, alarm_min;
    logic       alarm_arm, alarm_edit, snooze, dismiss;
    logic       buzzer, ringing, snoozed;
    logic [4:0] snooze_hr;
    logic [5:0] snooze_min;
    logic [2:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       bz;
        logic       rg;
        logic       sz;
        bit         chk_tgt;
        logic [4:0] hr;
        logic [5:0] mn;
    } exp_t;

    exp_t sb_q[$];

    alarm_ring_ctrl #(
        .SNOOZE_MIN     (5),
        .RING_TIMEOUT_S (60),
        .MAX_SNOOZE     (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sec_tick_i   (sec_tick),
        .cur_hr_i     (cur_hr),
        .cur_min_i    (cur_min),
        .cur_sec_i    (cur_sec),
        .alarm_hr_i   (alarm_hr),
        .alarm_min_i  (alarm_min),
        .alarm_arm_i  (alarm_arm),
        .alarm_edit_i (alarm_edit),
        .snooze_i     (snooze),
        .dismiss_i    (dismiss),
        .buzzer_o     (buzzer),
        .ringing_o    (ringing),
        .snoozed_o    (snoozed),
        .snooze_hr_o  (snooze_hr),
        .snooze_min_o (snooze_min),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hr  = 5'(h);
        cur_min = 6'(m);
        cur_sec = 6'(s);
    endtask

    task automatic push_exp(input string tag, input int st, input bit bz, input bit rg,
                            input bit sz, input bit chk, input int hr, input int mn);
        exp_t e;
        e.tag = tag; e.st = 3'(st); e.bz = bz; e.rg = rg; e.sz = sz;
        e.chk_tgt = chk; e.hr = 5'(hr); e.mn = 6'(mn);
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        n_assert++;
        assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_assert++;
            assert ({state, buzzer, ringing, snoozed} === {e.st, e.bz, e.rg, e.sz}) else begin
                n_fail++;
                $error("FAIL %s: state/buzzer/ringing/snoozed observed %0d/%b/%b/%b expected %0d/%b/%b/%b",
                       e.tag, state, buzzer, ringing, snoozed, e.st, e.bz, e.rg, e.sz);
            end
            if (e.chk_tgt) begin
                n_assert++;
                assert ({snooze_hr, snooze_min} === {e.hr, e.mn}) else begin
                    n_fail++;
                    $error("FAIL %s_target: observed %0d:%0d expected %0d:%0d",
                           e.tag, snooze_hr, snooze_min, e.hr, e.mn);
                end
            end
        end
    endtask

    // One plain clock edge
    task automatic exp_cyc(input string tag, input int st, input bit bz, input bit rg, input bit sz);
        push_exp(tag, st, bz, rg, sz, 1'b0, 0, 0);
        tick();
        check_pop();
    endtask

    // One plain clock edge, also checking the snooze target
    task automatic exp_cyc_t(input string tag, input int st, input bit bz, input bit rg,
                             input bit sz, input int hr, input int mn);
        push_exp(tag, st, bz, rg, sz, 1'b1, hr, mn);
        tick();
        check_pop();
    endtask

    // Advance the clock display to h:m:s with a sec_tick pulse
    task automatic exp_sec(input string tag, input int h, input int m, input int s,
                           input int st, input bit bz, input bit rg, input bit sz);
        push_exp(tag, st, bz, rg, sz, 1'b0, 0, 0);
        set_time(h, m, s);
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        check_pop();
    endtask

    initial begin
        rst_n = 1'b0; sec_tick = 1'b0;
        alarm_arm = 1'b0; alarm_edit = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        alarm_hr = 5'd7; alarm_min = 6'd30;
        set_time(7, 29, 59);
        #2;
        push_exp("reset", 0, 0, 0, 0, 1'b1, 0, 0);
        check_pop();

        alarm_arm = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cyc("arm", 1, 0, 0, 0);

        // Editing suppresses the match at 07:30:00
        alarm_edit = 1'b1;
        exp_sec("edit_0730", 7, 30, 0, 1, 0, 0, 0);
        exp_cyc("edit_hold", 1, 0, 0, 0);
        alarm_edit = 1'b0;
        exp_sec("edit_after", 7, 30, 1, 1, 0, 0, 0);

        // Basic ring and buzzer toggle
        exp_sec("pre_alarm", 7, 29, 59, 1, 0, 0, 0);
        exp_sec("ring_start", 7, 30, 0, 2, 1, 1, 0);
        for (int s = 1; s <= 10; s++)
            exp_sec("ring_toggle", 7, 30, s, 2, (s % 2) == 0, 1, 0);

        // First snooze at 07:30:10 -> 07:35
        snooze = 1'b1;
        exp_cyc_t("snooze1", 3, 0, 0, 1, 7, 35);
        exp_cyc_t("snooze_ignored", 3, 0, 0, 1, 7, 35);
        snooze = 1'b0;
        exp_sec("snooze_wait", 7, 34, 59, 3, 0, 0, 1);
        exp_sec("snooze_wake", 7, 35, 0, 2, 1, 1, 0);

        // Second snooze honoured, third acts as dismiss
        set_time(7, 35, 3);
        snooze = 1'b1;
        exp_cyc_t("snooze2", 3, 0, 0, 1, 7, 40);
        snooze = 1'b0;
        exp_sec("snooze2_wake", 7, 40, 0, 2, 1, 1, 0);
        snooze = 1'b1;
        exp_cyc_t("snooze3_done", 4, 0, 0, 0, 7, 40);
        snooze = 1'b0;
        exp_cyc("done_rearm", 1, 0, 0, 0);

        // Ring timeout after 60 ticks
        exp_sec("tout_ring", 7, 30, 0, 2, 1, 1, 0);
        for (int k = 1; k <= 59; k++)
            exp_sec("tout_toggle", 7, 30, k, 2, (k % 2) == 0, 1, 0);
        exp_sec("timeout", 7, 30, 59, 4, 0, 0, 0);
        exp_cyc("done_hold", 4, 0, 0, 0);
        exp_sec("done_leave", 7, 31, 0, 1, 0, 0, 0);
        exp_sec("rering", 7, 30, 0, 2, 1, 1, 0);

        // Snooze and dismiss together: dismiss wins, no target latch
        snooze = 1'b1; dismiss = 1'b1;
        exp_cyc_t("snooze_dismiss", 4, 0, 0, 0, 7, 40);
        snooze = 1'b0; dismiss = 1'b0;
        exp_cyc("done_same_min", 4, 0, 0, 0);

        // Midnight wrap of the snooze target
        alarm_hr = 5'd23; alarm_min = 6'd58;
        exp_sec("wrap_leave", 23, 57, 59, 1, 0, 0, 0);
        exp_sec("wrap_ring", 23, 58, 0, 2, 1, 1, 0);
        set_time(23, 58, 5);
        snooze = 1'b1;
        exp_cyc_t("wrap_snooze", 3, 0, 0, 1, 0, 3);
        snooze = 1'b0;
        exp_sec("wrap_wake", 0, 3, 0, 2, 1, 1, 0);
        snooze = 1'b1;
        exp_cyc_t("wrap_snooze2", 3, 0, 0, 1, 0, 8);
        snooze = 1'b0;
        dismiss = 1'b1;
        exp_cyc_t("snoozed_dismiss", 4, 0, 0, 0, 0, 8);
        dismiss = 1'b0;
        exp_cyc("wrap_rearm", 1, 0, 0, 0);

        // Edit while ringing does not abort; disarm does
        exp_sec("abort_ring", 23, 58, 0, 2, 1, 1, 0);
        alarm_edit = 1'b1;
        exp_cyc("edit_in_ring", 2, 1, 1, 0);
        alarm_edit = 1'b0;
        alarm_arm = 1'b0;
        exp_cyc("disarm", 0, 0, 0, 0);
        alarm_arm = 1'b1;
        exp_cyc("rearm", 1, 0, 0, 0);
        exp_cyc("ring_again", 2, 1, 1, 0);

        // Asynchronous reset mid-ring, checked before any further edge
        #3;
        rst_n = 1'b0;
        #1;
        push_exp("async_reset", 0, 0, 0, 0, 1'b1, 0, 0);
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        set_time(0, 0, 1);
        exp_cyc("post_reset", 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of sequence");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alarm_ring_ctrl
`default_nettype wire
